// File: rtl/exe_muldiv_unit.sv
// Iterative 32-bit unsigned multiply / divide / remainder unit for the EX stage.
// Optional macro MULDIV_EARLY_OUT_EN: a zero operand B completes at accept, with no RUN phase.
module exe_muldiv_unit #(
    parameter int         WIDTH   = 32,
    parameter logic [3:0] CMD_MUL = 4'b1010,
    parameter logic [3:0] CMD_DIV = 4'b1011,
    parameter logic [3:0] CMD_REM = 4'b1100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       EXE_CMD,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    input  logic [4:0]       dest,
    input  logic             WB_EN,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       dest_out,
    output logic             WB_EN_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       cmd_q, cmd_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [4:0]       dest_lat_q, dest_lat_d;
    logic             wb_lat_q, wb_lat_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [4:0]       dest_out_q, dest_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             wb_en_out_q, wb_en_out_d;

    logic             cmd_ok_s;
    logic             accept_s;
    logic [WIDTH:0]   rem_shift_s;
    logic [WIDTH:0]   rem_diff_s;
    logic [WIDTH-1:0] iter_a_s;
    logic [WIDTH-1:0] iter_b_s;
    logic [WIDTH-1:0] iter_acc_s;
    logic [WIDTH-1:0] final_s;

    // One iteration: shift-add for multiply, restoring step for divide/remainder.
    // Division keeps the partial remainder in acc and builds the quotient in a,
    // shifting dividend bits out of a's MSB as quotient bits enter its LSB.
    always_comb begin
        rem_shift_s = {acc_q, a_q[WIDTH-1]};
        rem_diff_s  = rem_shift_s - {1'b0, b_q};
        iter_a_s    = a_q;
        iter_b_s    = b_q;
        iter_acc_s  = acc_q;
        if (cmd_q == CMD_MUL) begin
            iter_acc_s = b_q[0] ? (acc_q + a_q) : acc_q;
            iter_a_s   = {a_q[WIDTH-2:0], 1'b0};
            iter_b_s   = {1'b0, b_q[WIDTH-1:1]};
        end else if (!rem_diff_s[WIDTH]) begin
            iter_acc_s = rem_diff_s[WIDTH-1:0];
            iter_a_s   = {a_q[WIDTH-2:0], 1'b1};
        end else begin
            iter_acc_s = rem_shift_s[WIDTH-1:0];
            iter_a_s   = {a_q[WIDTH-2:0], 1'b0};
        end
    end

    // Select the completed value from the last iteration's outputs.
    always_comb begin
        if (cmd_q == CMD_DIV) begin
            final_s = iter_a_s;
        end else begin
            final_s = iter_acc_s;
        end
    end

    // Command decode and accept qualification.
    always_comb begin
        cmd_ok_s = (EXE_CMD == CMD_MUL) || (EXE_CMD == CMD_DIV) || (EXE_CMD == CMD_REM);
        accept_s = start && cmd_ok_s && !flush;
    end

    // Next-state and datapath register computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        dest_lat_d = dest_lat_q;
        wb_lat_d   = wb_lat_q;
        result_d   = result_q;
        dest_out_d = dest_out_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept_s) begin
                    cmd_d      = EXE_CMD;
                    a_d        = val1;
                    b_d        = val2;
                    acc_d      = '0;
                    cnt_d      = '0;
                    dest_lat_d = dest;
                    wb_lat_d   = WB_EN;
`ifdef MULDIV_EARLY_OUT_EN
                    if (val2 == '0) begin
                        state_d    = S_DONE;
                        dest_out_d = dest;
                        if (EXE_CMD == CMD_MUL) begin
                            result_d = '0;
                        end else if (EXE_CMD == CMD_DIV) begin
                            result_d = '1;
                        end else begin
                            result_d = val1;
                        end
                    end else begin
                        state_d = S_RUN;
                    end
`else
                    state_d = S_RUN;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    a_d   = iter_a_s;
                    b_d   = iter_b_s;
                    acc_d = iter_acc_s;
                    if (cnt_q == LAST_ITER) begin
                        state_d    = S_DONE;
                        result_d   = final_s;
                        dest_out_d = dest_lat_q;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they appear registered.
    always_comb begin
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
        if (state_d == S_DONE) begin
            wb_en_out_d = wb_lat_d;
        end else begin
            wb_en_out_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cmd_q       <= 4'b0000;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            dest_lat_q  <= 5'd0;
            wb_lat_q    <= 1'b0;
            result_q    <= '0;
            dest_out_q  <= 5'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wb_en_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            dest_lat_q  <= dest_lat_d;
            wb_lat_q    <= wb_lat_d;
            result_q    <= result_d;
            dest_out_q  <= dest_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wb_en_out_q <= wb_en_out_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign dest_out  = dest_out_q;
    assign WB_EN_out = wb_en_out_q;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Directed self-checking bench for exe_muldiv_unit.
module tb_exe_muldiv_unit;

    localparam logic [3:0] CMD_MUL = 4'b1010;
    localparam logic [3:0] CMD_DIV = 4'b1011;
    localparam logic [3:0] CMD_REM = 4'b1100;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  EXE_CMD;
    logic [31:0] val1;
    logic [31:0] val2;
    logic [4:0]  dest;
    logic        WB_EN;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  dest_out;
    logic        WB_EN_out;

    int checks = 0;
    int failures = 0;

    exe_muldiv_unit dut (
        .clk(clk), .rst(rst), .start(start), .EXE_CMD(EXE_CMD),
        .val1(val1), .val2(val2), .dest(dest), .WB_EN(WB_EN), .flush(flush),
        .busy(busy), .done(done), .result(result), .dest_out(dest_out),
        .WB_EN_out(WB_EN_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; EXE_CMD = 4'b0000; val1 = 32'd0; val2 = 32'd0;
        dest = 5'd0; WB_EN = 1'b0; flush = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        checks++;
        if ({busy, done, result, dest_out, WB_EN_out} !== 39'd0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b result=%h dest=%0d wb=%b expected all 0",
                     busy, done, result, dest_out, WB_EN_out);
        end
    endtask

    task automatic run_op(input string nm, input logic [3:0] cmd, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] d, input logic wb,
                          input logic [31:0] exp, input int exp_busy);
        int busy_cnt = 0;
        int cyc = 0;
        start = 1'b1; EXE_CMD = cmd; val1 = a; val2 = b; dest = d; WB_EN = wb;
        step();
        start = 1'b0;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) busy_cnt++;
            step();
            cyc++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout got done=%b expected 1 within 100 cycles", nm, done);
        end
        checks++;
        if (busy_cnt !== exp_busy) begin
            failures++;
            $display("FAIL %s_busy_cycles got %0d expected %0d", nm, busy_cnt, exp_busy);
        end
        checks++;
        if (result !== exp || dest_out !== d || WB_EN_out !== wb || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_result got result=%h dest=%0d wb=%b busy=%b expected result=%h dest=%0d wb=%b busy=0",
                     nm, result, dest_out, WB_EN_out, busy, exp, d, wb);
        end
        step();
        checks++;
        if (done !== 1'b0 || WB_EN_out !== 1'b0 || result !== exp || dest_out !== d) begin
            failures++;
            $display("FAIL %s_after_done got done=%b wb=%b result=%h dest=%0d expected done=0 wb=0 result=%h dest=%0d",
                     nm, done, WB_EN_out, result, dest_out, exp, d);
        end
    endtask

    task automatic test_arith();
        run_op("mul_7x6", CMD_MUL, 32'd7, 32'd6, 5'd5, 1'b1, 32'd42, 32);
        run_op("div_100_7", CMD_DIV, 32'd100, 32'd7, 5'd3, 1'b1, 32'd14, 32);
        run_op("rem_100_7", CMD_REM, 32'd100, 32'd7, 5'd4, 1'b0, 32'd2, 32);
        run_op("mul_wrap", CMD_MUL, 32'hFFFF_FFFF, 32'd2, 5'd31, 1'b1, 32'hFFFF_FFFE, 32);
        run_op("div_big", CMD_DIV, 32'hFFFF_FFFF, 32'h0001_0000, 5'd8, 1'b1, 32'h0000_FFFF, 32);
        run_op("rem_big", CMD_REM, 32'hDEAD_BEEF, 32'd1000, 5'd9, 1'b1, 32'd559, 32);
    endtask

    task automatic test_div_zero();
`ifdef MULDIV_EARLY_OUT_EN
        run_op("div_zero", CMD_DIV, 32'h1234, 32'd0, 5'd10, 1'b1, 32'hFFFF_FFFF, 0);
        run_op("rem_zero", CMD_REM, 32'h1234, 32'd0, 5'd11, 1'b1, 32'h0000_1234, 0);
`else
        run_op("div_zero", CMD_DIV, 32'h1234, 32'd0, 5'd10, 1'b1, 32'hFFFF_FFFF, 32);
        run_op("rem_zero", CMD_REM, 32'h1234, 32'd0, 5'd11, 1'b1, 32'h0000_1234, 32);
`endif
    endtask

    task automatic test_abort(input logic use_rst);
        logic [31:0] prev;
        int saw_done = 0;
        prev = result;
        start = 1'b1; EXE_CMD = CMD_MUL; val1 = 32'd3; val2 = 32'd5; dest = 5'd12; WB_EN = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        if (use_rst) rst = 1'b1;
        else flush = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0;
        checks++;
        if (use_rst) begin
            if ({busy, done, result, dest_out, WB_EN_out} !== 39'd0) begin
                failures++;
                $display("FAIL rst_abort got busy=%b done=%b result=%h dest=%0d wb=%b expected all 0",
                         busy, done, result, dest_out, WB_EN_out);
            end
        end else begin
            if (busy !== 1'b0 || done !== 1'b0 || WB_EN_out !== 1'b0 || result !== prev) begin
                failures++;
                $display("FAIL flush_abort got busy=%b done=%b wb=%b result=%h expected busy=0 done=0 wb=0 result=%h",
                         busy, done, WB_EN_out, result, prev);
            end
        end
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1 || busy === 1'b1) saw_done++;
            step();
        end
        checks++;
        if (saw_done !== 0) begin
            failures++;
            $display("FAIL abort_quiet (rst=%b) got %0d active cycles expected 0", use_rst, saw_done);
        end
    endtask

    task automatic test_illegal_cmd();
        int active = 0;
        start = 1'b1; EXE_CMD = 4'b0001; val1 = 32'd9; val2 = 32'd9; dest = 5'd2; WB_EN = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy === 1'b1 || done === 1'b1 || WB_EN_out === 1'b1) active++;
            step();
        end
        checks++;
        if (active !== 0) begin
            failures++;
            $display("FAIL illegal_cmd got %0d active cycles expected 0", active);
        end
    endtask

    task automatic test_start_mid_run();
        int cyc = 0;
        start = 1'b1; EXE_CMD = CMD_MUL; val1 = 32'd7; val2 = 32'd6; dest = 5'd5; WB_EN = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        start = 1'b1; EXE_CMD = CMD_DIV; val1 = 32'd81; val2 = 32'd9; dest = 5'd20;
        step();
        start = 1'b0;
        while (done !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
        checks++;
        if (done !== 1'b1 || result !== 32'd42 || dest_out !== 5'd5 || cyc !== 26) begin
            failures++;
            $display("FAIL start_mid_run got done=%b result=%h dest=%0d wait=%0d expected done=1 result=0000002a dest=5 wait=26",
                     done, result, dest_out, cyc);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int cyc = 0;
        int gap = 0;
        start = 1'b1; EXE_CMD = CMD_MUL; val1 = 32'd3; val2 = 32'd4; dest = 5'd7; WB_EN = 1'b1;
        step();
        while (done !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
        checks++;
        if (done !== 1'b1 || result !== 32'd12 || dest_out !== 5'd7) begin
            failures++;
            $display("FAIL b2b_first got done=%b result=%h dest=%0d expected done=1 result=0000000c dest=7",
                     done, result, dest_out);
        end
        val1 = 32'd5; val2 = 32'd6; dest = 5'd9;
        step();
        start = 1'b0;
        gap = 1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_reaccept got busy=%b done=%b expected busy=1 done=0", busy, done);
        end
        while (done !== 1'b1 && gap < 100) begin
            step();
            gap++;
        end
        checks++;
        if (gap !== 33 || result !== 32'd30 || dest_out !== 5'd9 || WB_EN_out !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second got gap=%0d result=%h dest=%0d wb=%b expected gap=33 result=0000001e dest=9 wb=1",
                     gap, result, dest_out, WB_EN_out);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_arith();
        test_div_zero();
        test_abort(1'b0);
        test_abort(1'b1);
        test_illegal_cmd();
        test_start_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
